circle_cmd_dispatch: RTL and testbench

CIRCLE_CMD_DISPATCH -- requirements
Module: circle_cmd_dispatch

---
 rtl/circle_cmd_dispatch.sv | 127 ++++++++++++
 tb/tb_circle_cmd_dispatch.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/circle_cmd_dispatch.sv
// Command dispatcher: pops circle commands (opcode/color word, then an argument word)
// from a FWFT FIFO and drives the circle engine. Define CIRCLE_DISPATCH_STATS_EN to enable circle_count.
module circle_cmd_dispatch #(
  parameter logic [7:0] OP_CIRCLE = 8'h03,
  parameter logic [7:0] OP_NOP    = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_empty,
  input  logic [31:0] cmd_dout,
  output logic        cmd_rd_en,
  input  logic        CE_ready,
  output logic [23:0] CE_color,
  output logic        CE_color_valid,
  output logic [31:0] CE_arguments,
  output logic        CE_arguments_valid,
  output logic        CE_trigger,
  output logic        busy,
  output logic        err_unknown_op,
  output logic [15:0] circle_count
);

  typedef enum logic [2:0] {
    IDLE,
    ARGS,
    TRIG,
    WAIT_LOW,
    WAIT_READY
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_pop;
  logic        w_color_load;
  logic        w_args_load;
  logic        w_bad_op;
  logic [7:0]  w_opcode;

  logic [23:0] r_color;
  logic        r_color_valid;
  logic [31:0] r_arguments;
  logic        r_arguments_valid;
  logic        r_trigger;
  logic        r_err;

  assign w_opcode = cmd_dout[31:24];

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_color_load = 1'b0;
    w_args_load  = 1'b0;
    w_bad_op     = 1'b0;
    case (r_state)
      IDLE: begin
        if (CE_ready && !cmd_empty) begin
          w_pop = 1'b1;
          if (w_opcode == OP_CIRCLE) begin
            w_color_load = 1'b1;
            w_state_next = ARGS;
          end else if (w_opcode != OP_NOP) begin
            w_bad_op = 1'b1;
          end
        end
      end
      // The argument word is never opcode-decoded, whatever its top byte holds.
      ARGS: begin
        if (!cmd_empty) begin
          w_pop        = 1'b1;
          w_args_load  = 1'b1;
          w_state_next = TRIG;
        end
      end
      TRIG:       w_state_next = WAIT_LOW;
      WAIT_LOW:   if (!CE_ready) w_state_next = WAIT_READY;
      WAIT_READY: if (CE_ready) w_state_next = IDLE;
      default:    w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state           <= IDLE;
      r_color           <= 24'h0;
      r_color_valid     <= 1'b0;
      r_arguments       <= 32'h0;
      r_arguments_valid <= 1'b0;
      r_trigger         <= 1'b0;
      r_err             <= 1'b0;
    end else begin
      r_state           <= w_state_next;
      r_color_valid     <= w_color_load;
      r_arguments_valid <= w_args_load;
      r_trigger         <= (r_state == TRIG);
      r_err             <= r_err | w_bad_op;
      if (w_color_load) r_color <= cmd_dout[23:0];
      if (w_args_load) r_arguments <= cmd_dout;
    end
  end

`ifdef CIRCLE_DISPATCH_STATS_EN
  logic [15:0] r_circle_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_circle_count <= 16'h0000;
    end else if (r_state == TRIG) begin
      r_circle_count <= r_circle_count + 16'h0001;
    end
  end

  assign circle_count = r_circle_count;
`else
  assign circle_count = 16'h0000;
`endif

  // Reset must never consume a FIFO word, even though the FSM still sees IDLE/ARGS.
  assign cmd_rd_en          = w_pop & ~rst;
  assign CE_color           = r_color;
  assign CE_color_valid     = r_color_valid;
  assign CE_arguments       = r_arguments;
  assign CE_arguments_valid = r_arguments_valid;
  assign CE_trigger         = r_trigger;
  assign busy               = (r_state != IDLE);
  assign err_unknown_op     = r_err;

endmodule

// File: tb/tb_circle_cmd_dispatch.sv
// Directed bench for circle_cmd_dispatch: FWFT FIFO model, pulse scoreboard, timing checks.
module tb_circle_cmd_dispatch;

`ifdef CIRCLE_DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam int K_COLOR = 1;
  localparam int K_ARGS  = 2;
  localparam int K_TRIG  = 3;

  typedef struct {
    int          kind;
    logic [31:0] data;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_empty = 1'b1;
  logic [31:0] cmd_dout = 32'h0;
  logic        cmd_rd_en;
  logic        CE_ready = 1'b0;
  logic [23:0] CE_color;
  logic        CE_color_valid;
  logic [31:0] CE_arguments;
  logic        CE_arguments_valid;
  logic        CE_trigger;
  logic        busy;
  logic        err_unknown_op;
  logic [15:0] circle_count;

  circle_cmd_dispatch dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_empty          (cmd_empty),
    .cmd_dout           (cmd_dout),
    .cmd_rd_en          (cmd_rd_en),
    .CE_ready           (CE_ready),
    .CE_color           (CE_color),
    .CE_color_valid     (CE_color_valid),
    .CE_arguments       (CE_arguments),
    .CE_arguments_valid (CE_arguments_valid),
    .CE_trigger         (CE_trigger),
    .busy               (busy),
    .err_unknown_op     (err_unknown_op),
    .circle_count       (circle_count)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [31:0] fifo[$];
  sb_t         sb[$];
  int          pop_log[$];
  int          evt_cnt[4];
  int          evt_cyc[4];
  bit          pop_now;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    cmd_empty = (fifo.size() == 0);
    cmd_dout  = cmd_empty ? 32'h0 : fifo[0];
  endtask

  task automatic push(input logic [31:0] w);
    fifo.push_back(w);
    refresh();
  endtask

  task automatic expect_evt(input int kind, input logic [31:0] data);
    sb_t e;
    e.kind = kind;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int kind, input logic [31:0] data);
    sb_t e;
    evt_cnt[kind]++;
    evt_cyc[kind] = cyc;
    if (sb.size() == 0) begin
      chk("unexpected_pulse", kind, 0);
    end else begin
      e = sb.pop_front();
      chk("pulse_kind", kind, e.kind);
      chk("pulse_data", data, e.data);
      $display("[TB] cyc %0d pulse kind=%0d data=%08h", cyc, kind, data);
    end
  endtask

  // One clock: observe at the falling edge, then advance the FIFO after the rising edge.
  task automatic step();
    @(negedge clk);
    pop_now = cmd_rd_en;
    chk("rd_en_while_empty", {31'h0, cmd_rd_en & cmd_empty}, 0);
    chk("rd_en_in_reset", {31'h0, cmd_rd_en & rst}, 0);
    chk("pulse_onehot_ok",
        {31'h0, (32'(CE_color_valid) + 32'(CE_arguments_valid) + 32'(CE_trigger)) <= 1}, 1);
    if (cmd_rd_en) begin
      pop_log.push_back(cyc);
      evt_cnt[0]++;
      evt_cyc[0] = cyc;
      $display("[TB] cyc %0d pop %08h", cyc, cmd_dout);
    end
    if (CE_color_valid) sb_check(K_COLOR, {8'h00, CE_color});
    if (CE_arguments_valid) sb_check(K_ARGS, CE_arguments);
    if (CE_trigger) sb_check(K_TRIG, 32'h0);
    @(posedge clk);
    cyc++;
    #1;
    if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
    refresh();
  endtask

  task automatic wait_evt(input int sel, input int target, input string tag);
    int b;
    b = 0;
    while (evt_cnt[sel] < target && b < 60) begin
      step();
      b++;
    end
    chk(tag, evt_cnt[sel], target);
  endtask

  task automatic finish_cmd();
    CE_ready = 1'b0;
    step();
    CE_ready = 1'b1;
    step();
    step();
    chk("busy_after_cmd", {31'h0, busy}, 0);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_color", {8'h0, CE_color}, 0);
    chk("rst_args", CE_arguments, 0);
    chk("rst_pulses", {29'h0, CE_color_valid, CE_arguments_valid, CE_trigger}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_err", {31'h0, err_unknown_op}, 0);
    chk("rst_count", {16'h0, circle_count}, 0);
  endtask

  initial begin
    int p0;
    int base;
    int rise;
    int t0;
    for (int i = 0; i < 4; i++) begin
      evt_cnt[i] = 0;
      evt_cyc[i] = 0;
    end
    apply_reset();

    // Back-to-back command with both words present
    CE_ready = 1'b1;
    push(32'h03FF0000);
    push(32'h0A01E032);
    expect_evt(K_COLOR, 32'h00FF0000);
    expect_evt(K_ARGS, 32'h0A01E032);
    expect_evt(K_TRIG, 32'h0);
    wait_evt(K_TRIG, 1, "t1_trigger_seen");
    t0 = pop_log[0];
    chk("t1_word1_pop", pop_log[1], t0 + 1);
    chk("t1_color_cyc", evt_cyc[K_COLOR], t0 + 1);
    chk("t1_args_cyc", evt_cyc[K_ARGS], t0 + 2);
    chk("t1_trig_cyc", evt_cyc[K_TRIG], t0 + 3);
    chk("t1_busy_wait_low", {31'h0, busy}, 1);
    chk("t1_color_held", {8'h0, CE_color}, 32'h00FF0000);
    finish_cmd();

    // Argument word arrives ten cycles late
    push(32'h03123456);
    expect_evt(K_COLOR, 32'h00123456);
    wait_evt(K_COLOR, 2, "t2_color_seen");
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_busy_waiting", {31'h0, busy}, 1);
      chk("t2_no_early_args", evt_cnt[K_ARGS], 1);
    end
    push(32'h0050A00C);
    expect_evt(K_ARGS, 32'h0050A00C);
    expect_evt(K_TRIG, 32'h0);
    wait_evt(K_TRIG, 2, "t2_trigger_seen");
    chk("t2_args_after_pop", evt_cyc[K_ARGS], pop_log[pop_log.size() - 1] + 1);
    finish_cmd();

    // NOP then unknown opcode: both popped, no pulses, sticky error
    chk("t3_err_before", {31'h0, err_unknown_op}, 0);
    p0 = evt_cnt[0];
    push(32'h00000000);
    push(32'h7F123456);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_busy_low", {31'h0, busy}, 0);
    end
    chk("t3_two_pops", evt_cnt[0], p0 + 2);
    chk("t3_no_color", evt_cnt[K_COLOR], 2);
    chk("t3_err_set", {31'h0, err_unknown_op}, 1);

    // Two queued commands, engine stalls after the first trigger
    apply_reset();
    CE_ready = 1'b1;
    base = pop_log.size();
    push(32'h03AABBCC);
    push(32'h00100200);
    push(32'h03010203);
    push(32'hFFFFFFFF);
    expect_evt(K_COLOR, 32'h00AABBCC);
    expect_evt(K_ARGS, 32'h00100200);
    expect_evt(K_TRIG, 32'h0);
    expect_evt(K_COLOR, 32'h00010203);
    expect_evt(K_ARGS, 32'hFFFFFFFF);
    expect_evt(K_TRIG, 32'h0);
    wait_evt(K_TRIG, 3, "t4_first_trigger");
    CE_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("t4_no_pop_stalled", pop_log.size(), base + 2);
    end
    CE_ready = 1'b1;
    rise = cyc;
    wait_evt(K_TRIG, 4, "t4_second_trigger");
    chk("t4_pop_after_ready", {31'h0, pop_log[base + 2] > rise}, 1);
    chk("t4_args_no_decode", CE_arguments, 32'hFFFFFFFF);
    finish_cmd();

    // Reset while waiting for the argument word
    push(32'h03ABCDEF);
    expect_evt(K_COLOR, 32'h00ABCDEF);
    wait_evt(K_COLOR, 5, "t5_color_seen");
    chk("t5_busy_args", {31'h0, busy}, 1);
    rst = 1'b1;
    push(32'h03445566);
    chk("t5_no_pop_in_reset", {31'h0, cmd_rd_en}, 0);
    step();
    rst = 1'b0;
    chk("t5_rst_color", {8'h0, CE_color}, 0);
    chk("t5_rst_args", CE_arguments, 0);
    chk("t5_rst_busy", {31'h0, busy}, 0);
    chk("t5_rst_count", {16'h0, circle_count}, 0);
    expect_evt(K_COLOR, 32'h00445566);
    wait_evt(K_COLOR, 6, "t5_word_as_opcode");
    push(32'h11111111);
    expect_evt(K_ARGS, 32'h11111111);
    expect_evt(K_TRIG, 32'h0);
    wait_evt(K_TRIG, 5, "t5_trigger_seen");
    finish_cmd();

    // Two more circles since the last reset make three
    for (int i = 0; i < 2; i++) begin
      push(32'h03000010 + 32'(i));
      push(32'h00200000 + 32'(i));
      expect_evt(K_COLOR, 32'h00000010 + 32'(i));
      expect_evt(K_ARGS, 32'h00200000 + 32'(i));
      expect_evt(K_TRIG, 32'h0);
      wait_evt(K_TRIG, 6 + i, "t6_trigger_seen");
      finish_cmd();
    end
    chk("t6_circle_count", {16'h0, circle_count}, STATS ? 32'd3 : 32'd0);
    chk("sb_drained", sb.size(), 0);
    chk("fifo_drained", fifo.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
